// File: rtl/cpu_pkg.sv
// Shared widths, ALU opcodes, forward-select codes and multiply FSM states
// for the 16-bit pipelined CPU.
package cpu_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'b00,
    MUL_BUSY = 2'b01,
    MUL_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/seq_mul16.sv
// Iterative shift-add multiplier: latches operands on start, performs one
// step per cycle while busy, then presents the low DW product bits in DONE.
module seq_mul16 #(
  parameter int unsigned DW         = 16,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] product
);
  import cpu_pkg::*;

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mul_state_t    state, state_next;
  logic [CW-1:0] count;
  logic [DW-1:0] mcand, mplier, acc;
  logic          load, step;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs; busy is asserted in the issue cycle
  // itself so the pipeline freezes before the first step is taken.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (start) begin
          busy       = 1'b1;
          load       = 1'b1;
          state_next = MUL_BUSY;
        end
      end
      MUL_BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        if (count == '0) state_next = MUL_DONE;
      end
      MUL_DONE: begin
        done       = 1'b1;
        state_next = MUL_IDLE;
      end
      default: state_next = MUL_IDLE;
    endcase
    if (rst) begin
      busy = 1'b0;
      done = 1'b0;
    end
  end

  // Operand latch, iteration counter and accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      count  <= CW'(MUL_CYCLES - 1);
    end else if (step) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count != '0) count <= count - 1'b1;
    end
  end

  assign product = acc;

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative multiply
// with pipeline stall, branch/jump resolution and the E->M pipeline register.
module execute_cycle #(
  parameter int unsigned DW         = cpu_pkg::DW,
  parameter int unsigned AW         = cpu_pkg::AW,
  parameter int unsigned MUL_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          RegwriteE,
  input  logic [1:0]    ResultSrcE,
  input  logic          MemwriteE,
  input  logic          JumpE,
  input  logic          BranchE,
  input  logic [3:0]    ALUControlE,
  input  logic          ALUSrcE,
  input  logic [DW-1:0] RD1E,
  input  logic [DW-1:0] RD2E,
  input  logic [DW-1:0] ImmExtE,
  input  logic [AW-1:0] RdE,
  input  logic [DW-1:0] pcE,
  input  logic [DW-1:0] pc_plus4E,
  input  logic [1:0]    ForwardAE,
  input  logic [1:0]    ForwardBE,
  input  logic [DW-1:0] ResultW,
  output logic          StallE,
  output logic          PCSrcE,
  output logic [DW-1:0] PCTargetE,
  output logic          RegwriteM,
  output logic [1:0]    ResultSrcM,
  output logic          MemwriteM,
  output logic [AW-1:0] RdM,
  output logic [DW-1:0] ALUResultM,
  output logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] pc_plus4M
);
  import cpu_pkg::*;

  logic [DW-1:0] src_a, fwd_b, src_b, alu_result, product;
  logic          mul_busy, mul_done, zero;
  logic [3:0]    shamt;

  // Forward muxes for both operands, then immediate select for B
  always_comb begin
    case (ForwardAE)
      FWD_WB:  src_a = ResultW;
      FWD_MEM: src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      FWD_WB:  fwd_b = ResultW;
      FWD_MEM: fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  assign shamt = src_b[3:0];

  // Single-cycle ALU; MUL selects the multiplier accumulator, which is only
  // consumed by the M register in the DONE cycle
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      ALU_ADD: alu_result = src_a + src_b;
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(DW-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      ALU_SLL: alu_result = src_a << shamt;
      ALU_SRL: alu_result = src_a >> shamt;
      ALU_SRA: alu_result = DW'($signed(src_a) >>> shamt);
      ALU_MUL: alu_result = product;
      default: alu_result = '0;
    endcase
  end

  seq_mul16 #(
    .DW         (DW),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (ALUControlE == ALU_MUL),
    .a       (src_a),
    .b       (src_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  assign StallE    = mul_busy;
  assign zero      = (src_a == src_b);
  assign PCTargetE = pcE + ImmExtE;
  assign PCSrcE    = ~rst & (JumpE | (BranchE & zero));

  // E->M pipeline register; a stalled cycle pushes a bubble downstream
  always_ff @(posedge clk) begin
    if (rst || StallE) begin
      RegwriteM  <= 1'b0;
      ResultSrcM <= '0;
      MemwriteM  <= 1'b0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      pc_plus4M  <= '0;
    end else begin
      RegwriteM  <= RegwriteE;
      ResultSrcM <= ResultSrcE;
      MemwriteM  <= MemwriteE;
      RdM        <= RdE;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      pc_plus4M  <= pc_plus4E;
    end
  end

  logic unused_done;
  assign unused_done = mul_done;

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: ALU/forwarding vector table, branch,
// reset and multi-cycle multiply sequences.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegwriteE, MemwriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]  ALUControlE;
  logic [15:0] RD1E, RD2E, ImmExtE, pcE, pc_plus4E, ResultW;
  logic [2:0]  RdE;
  logic        StallE, PCSrcE;
  logic [15:0] PCTargetE;
  logic        RegwriteM, MemwriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  RdM;
  logic [15:0] ALUResultM, WriteDataM, pc_plus4M;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  execute_cycle #(.DW(16), .AW(3), .MUL_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .RegwriteE(RegwriteE), .ResultSrcE(ResultSrcE), .MemwriteE(MemwriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RdE(RdE), .pcE(pcE), .pc_plus4E(pc_plus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegwriteM(RegwriteM), .ResultSrcM(ResultSrcM), .MemwriteM(MemwriteM),
    .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .pc_plus4M(pc_plus4M)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] imm;
    logic        src;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] rw;
    logic [15:0] exp_res;
    logic [15:0] exp_wd;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [3:0] op, input logic [15:0] rd1,
                              input logic [15:0] rd2, input logic [15:0] imm,
                              input logic src, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [15:0] rw,
                              input logic [15:0] exp_res, input logic [15:0] exp_wd);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.src = src;
    v.fa = fa; v.fb = fb; v.rw = rw; v.exp_res = exp_res; v.exp_wd = exp_wd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    RegwriteE = 1'b0; MemwriteE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
    ALUSrcE = 1'b0; ResultSrcE = 2'b00; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUControlE = 4'b0000; RD1E = '0; RD2E = '0; ImmExtE = '0; pcE = '0;
    pc_plus4E = '0; ResultW = '0; RdE = '0;
  endtask

  // Runs one multiply already presented on the inputs; returns stall length
  // and counts edges where the M register did not carry a bubble.
  task automatic run_mul(output int stall_cycles, output int bubble_bad,
                         input logic disturb_fwd);
    stall_cycles = 0;
    bubble_bad   = 0;
    #1;
    while (StallE === 1'b1 && stall_cycles < 40) begin
      stall_cycles++;
      tick;
      if (RegwriteM !== 1'b0 || MemwriteM !== 1'b0 || ALUResultM !== 16'h0 ||
          RdM !== 3'd0 || pc_plus4M !== 16'h0)
        bubble_bad++;
      if (disturb_fwd && stall_cycles == 1) begin
        ForwardAE = 2'b01;
        ResultW   = 16'hFFFF;
        #1;
      end
    end
  endtask

  int sc, bb;

  initial begin
    // Vector table: ADD with W forward, shifts, SLT, logic ops, M forward
    vecs[0]  = mk(4'b0000, 16'h0001, 16'h0000, 16'h0005, 1'b1, 2'b01, 2'b00, 16'h0010, 16'h0015, 16'h0000);
    vecs[1]  = mk(4'b1000, 16'h8004, 16'h0001, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'hC002, 16'h0001);
    vecs[2]  = mk(4'b0101, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0001, 16'h0001);
    vecs[3]  = mk(4'b0111, 16'h8004, 16'h0001, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h4002, 16'h0001);
    vecs[4]  = mk(4'b0101, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'hFFFF);
    vecs[5]  = mk(4'b0010, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'hF000, 16'hFF00);
    vecs[6]  = mk(4'b0011, 16'hF0F0, 16'h0F00, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'hFFF0, 16'h0F00);
    vecs[7]  = mk(4'b0100, 16'hFFFF, 16'h00FF, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'hFF00, 16'h00FF);
    vecs[8]  = mk(4'b0000, 16'h0001, 16'h0000, 16'h0000, 1'b0, 2'b00, 2'b10, 16'h0000, 16'hFF01, 16'hFF00);
    vecs[9]  = mk(4'b0110, 16'h0001, 16'h0013, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0008, 16'h0013);
    vecs[10] = mk(4'b0000, 16'hFFFF, 16'h0002, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0001, 16'h0002);
    vecs[11] = mk(4'b0001, 16'h0000, 16'h0001, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'hFFFF, 16'h0001);
    vecs[12] = mk(4'b1111, 16'h1234, 16'h5678, 16'h0000, 1'b0, 2'b00, 2'b00, 16'h0000, 16'h0000, 16'h5678);
    vecs[13] = mk(4'b0001, 16'h0009, 16'h0000, 16'h0003, 1'b1, 2'b11, 2'b01, 16'h00AA, 16'h0006, 16'h00AA);
    vecs[14] = mk(4'b0110, 16'h00FF, 16'h0000, 16'h0008, 1'b1, 2'b00, 2'b00, 16'h0000, 16'hFF00, 16'h0000);
    vecs[15] = mk(4'b0000, 16'h0000, 16'h0001, 16'h0000, 1'b0, 2'b10, 2'b00, 16'h0000, 16'hFF01, 16'h0001);

    // Reset with random E inputs
    rst = 1'b1;
    idle_inputs();
    for (int k = 0; k < 2; k++) begin
      RegwriteE = 1'($urandom); MemwriteE = 1'($urandom); JumpE = 1'($urandom);
      BranchE = 1'($urandom); ALUSrcE = 1'($urandom); ResultSrcE = 2'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
      ALUControlE = (k == 0) ? 4'b1001 : 4'($urandom);
      RD1E = 16'($urandom); RD2E = RD1E; ImmExtE = 16'($urandom);
      pcE = 16'($urandom); pc_plus4E = 16'($urandom); ResultW = 16'($urandom);
      RdE = 3'($urandom);
      JumpE = 1'b1;
      #1;
      chk("rst_stall", {31'd0, StallE}, 32'd0);
      chk("rst_pcsrc", {31'd0, PCSrcE}, 32'd0);
      tick;
    end
    chk("rst_m_ctrl", {28'd0, RegwriteM, MemwriteM, ResultSrcM}, 32'd0);
    chk("rst_m_rd", {29'd0, RdM}, 32'd0);
    chk("rst_m_data", {ALUResultM, WriteDataM}, 32'd0);
    chk("rst_m_pc4", {16'd0, pc_plus4M}, 32'd0);

    rst = 1'b0;
    idle_inputs();
    tick;

    // Table-driven single-cycle ops
    for (int i = 0; i < 16; i++) begin
      ALUControlE = vecs[i].op; RD1E = vecs[i].rd1; RD2E = vecs[i].rd2;
      ImmExtE = vecs[i].imm; ALUSrcE = vecs[i].src; ForwardAE = vecs[i].fa;
      ForwardBE = vecs[i].fb; ResultW = vecs[i].rw;
      RegwriteE = 1'b1; RdE = 3'(i); pc_plus4E = 16'h0100 + 16'(i * 4);
      tick;
      chk($sformatf("vec%0d_result", i), {16'd0, ALUResultM}, {16'd0, vecs[i].exp_res});
      chk($sformatf("vec%0d_wdata", i), {16'd0, WriteDataM}, {16'd0, vecs[i].exp_wd});
      chk($sformatf("vec%0d_pass", i), {12'd0, RegwriteM, RdM, pc_plus4M},
          {12'd0, 1'b1, 3'(i), 16'h0100 + 16'(i * 4)});
    end

    // Branch taken / not taken / jump
    idle_inputs();
    ALUControlE = 4'b0001; RD1E = 16'h1234; RD2E = 16'h1234; BranchE = 1'b1;
    pcE = 16'h0040; ImmExtE = 16'hFFF8;
    #1;
    chk("br_taken", {31'd0, PCSrcE}, 32'd1);
    chk("br_target", {16'd0, PCTargetE}, 32'h0038);
    tick;
    chk("br_result", {16'd0, ALUResultM}, 32'h0000);
    RD2E = 16'h1235;
    #1;
    chk("br_not_taken", {31'd0, PCSrcE}, 32'd0);
    BranchE = 1'b0; JumpE = 1'b1;
    #1;
    chk("jump", {31'd0, PCSrcE}, 32'd1);
    tick;

    // MUL 300 x 250, then MUL 3 x 5 immediately after
    idle_inputs();
    ALUControlE = 4'b1001; RD1E = 16'd300; RD2E = 16'd250; RegwriteE = 1'b1; RdE = 3'd5;
    pc_plus4E = 16'h0200;
    run_mul(sc, bb, 1'b0);
    chk("mul1_stall_cycles", sc, 17);
    chk("mul1_bubbles", bb, 0);
    tick;
    chk("mul1_result", {16'd0, ALUResultM}, 32'h24F8);
    chk("mul1_ctrl", {28'd0, RegwriteM, RdM}, {28'd0, 1'b1, 3'd5});

    RD1E = 16'd3; RD2E = 16'd5; RdE = 3'd2; ForwardAE = 2'b00; ResultW = '0;
    run_mul(sc, bb, 1'b1);
    chk("mul2_stall_cycles", sc, 17);
    chk("mul2_bubbles", bb, 0);
    tick;
    chk("mul2_result", {16'd0, ALUResultM}, 32'h000F);

    // Reset during BUSY at count 7, then an ADD must run without stalling
    idle_inputs();
    ALUControlE = 4'b1001; RD1E = 16'd7; RD2E = 16'd9; RegwriteE = 1'b1;
    tick;
    for (int k = 0; k < 8; k++) tick;
    #1;
    chk("mid_busy_stall", {31'd0, StallE}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_stall", {31'd0, StallE}, 32'd0);
    tick;
    chk("mid_rst_m", {15'd0, RegwriteM, ALUResultM}, 32'd0);
    rst = 1'b0;
    idle_inputs();
    ALUControlE = 4'b0000; RD1E = 16'd2; RD2E = 16'd2; RegwriteE = 1'b1;
    #1;
    chk("post_rst_stall", {31'd0, StallE}, 32'd0);
    tick;
    chk("post_rst_add", {16'd0, ALUResultM}, 32'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
